// File: rtl/zphoton_pkg.sv
// zphoton_pkg: shared definitions for the photon gate counter.
//   zstateT          - frame FSM state encoding
//   CLK_PER_US_DEF   - default clock cycles per microsecond (50 MHz)
//   CNT_W_DEF        - default photon count width
//   GATE_W_DEF       - default gate-length input width (us)
package zphoton_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    LATCH = 2'd3
  } zstateT;

  localparam int CLK_PER_US_DEF = 50;
  localparam int CNT_W_DEF      = 32;
  localparam int GATE_W_DEF     = 16;

endpackage

// File: rtl/zpulse_sync.sv
// zpulse_sync: brings the asynchronous discriminator output into the iClk
// domain and turns each rising edge into a one-cycle strobe.
//   iClk   - clock
//   iRst   - synchronous active-high reset
//   iPulse - asynchronous discriminator output
//   oRise  - one-cycle strobe per synchronized rising edge
module zpulse_sync (
  input  logic iClk,
  input  logic iRst,
  input  logic iPulse,
  output logic oRise
);

  // [0] and [1] form the metastability synchronizer, [2] is the previous
  // synchronized value used for edge detection.
  logic [2:0] syncQ;

  // NOTE: non-blocking assignments make every flop sample the pre-edge value,
  // which is what turns this shift into a real 3-stage pipeline.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      syncQ <= '0;
    end else begin
      syncQ <= {syncQ[1:0], iPulse};
    end
  end

  assign oRise = syncQ[1] & ~syncQ[2];

endmodule

// File: rtl/zphoton_gate_counter.sv
// zphoton_gate_counter: counts photon edges in back-to-back gates of
// iGateUs microseconds and publishes each completed frame with a
// valid/ready handshake.
//   iClk, iRst      - clock, synchronous active-high reset
//   iEn             - run enable (frames acquired back-to-back while high)
//   iPulse          - asynchronous discriminator output, one photon per rise
//   iGateUs         - gate length in us, sampled in ARM (0 behaves as 1)
//   oCount          - photon count of the last completed frame
//   oOverflow       - that frame saturated
//   oFrameNo        - wrapping index of the frame in oCount
//   oValid, iReady  - result handshake
//   oNewDataUpdate  - one-cycle strobe per completed frame (LED)
//   oLost           - sticky: an unconsumed result was overwritten
module zphoton_gate_counter
  import zphoton_pkg::*;
#(
  parameter int CLK_PER_US = CLK_PER_US_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int GATE_W     = GATE_W_DEF
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEn,
  input  logic              iPulse,
  input  logic [GATE_W-1:0] iGateUs,
  output logic [CNT_W-1:0]  oCount,
  output logic              oOverflow,
  output logic [15:0]       oFrameNo,
  output logic              oValid,
  input  logic              iReady,
  output logic              oNewDataUpdate,
  output logic              oLost
);

  localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_US - 1);

  zstateT             state, stateNext;
  logic               rise;
  logic [PRE_W-1:0]   preCnt;
  logic               usTick;
  logic [GATE_W-1:0]  usCnt;
  logic [GATE_W-1:0]  gateLen;
  logic               gateDone;
  logic [CNT_W-1:0]   acc;
  logic               accOvf;

  zpulse_sync uPulseSync (
    .iClk   (iClk),
    .iRst   (iRst),
    .iPulse (iPulse),
    .oRise  (rise)
  );

  // The prescaler is held at 0 outside a gate, so the ARM cycle is phase 0
  // of the first microsecond and LATCH lands exactly G*CLK_PER_US cycles
  // after ARM.
  assign usTick   = ((state == ARM) || (state == COUNT)) && (preCnt == PRE_LAST);
  assign gateDone = (state == COUNT) && usTick && (usCnt == gateLen - 1'b1);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // NOTE: default first so every path assigns stateNext and no latch forms.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (iEn) stateNext = ARM;
      ARM:     stateNext = iEn ? COUNT : IDLE;
      COUNT: begin
        if (!iEn)          stateNext = IDLE;
        else if (gateDone) stateNext = LATCH;
      end
      LATCH:   stateNext = iEn ? ARM : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      preCnt  <= '0;
      usCnt   <= '0;
      gateLen <= GATE_W'(1);
    end else begin
      if ((state == ARM) || (state == COUNT)) begin
        preCnt <= usTick ? '0 : preCnt + 1'b1;
      end else begin
        preCnt <= '0;
      end

      if (state == ARM) begin
        usCnt   <= '0;
        gateLen <= (iGateUs == '0) ? GATE_W'(1) : iGateUs;
      end else if ((state == COUNT) && usTick) begin
        usCnt <= usCnt + 1'b1;
      end
    end
  end

  // The accumulator is emptied at the frame boundary rather than in ARM, so
  // an edge seen during LATCH or ARM is kept and opens the next frame.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      acc    <= '0;
      accOvf <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          acc    <= '0;
          accOvf <= 1'b0;
        end
        LATCH: begin
          acc    <= CNT_W'(rise);
          accOvf <= 1'b0;
        end
        default: begin
          if (rise) begin
            if (&acc) accOvf <= 1'b1;
            else      acc    <= acc + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oCount         <= '0;
      oOverflow      <= 1'b0;
      oFrameNo       <= '0;
      oValid         <= 1'b0;
      oNewDataUpdate <= 1'b0;
      oLost          <= 1'b0;
    end else begin
      oNewDataUpdate <= (state == LATCH);
      if (state == LATCH) begin
        oCount    <= acc;
        oOverflow <= accOvf;
        oFrameNo  <= oFrameNo + 1'b1;
        oValid    <= 1'b1;
        if (oValid && !iReady) oLost <= 1'b1;
      end else if (oValid && iReady) begin
        oValid <= 1'b0;
      end
    end
  end

endmodule
